// File: rtl/t09_pwm_dac.sv
// t09_pwm_dac: prescaled N-bit PWM DAC output stage with a one-deep sample buffer.
// Define T09_PWM_DAC_DEADBAND_EN to add a complementary pwm_out_n leg with a DB-cycle deadband.
module t09_pwm_dac #(
   parameter int N   = 8,
   parameter int DIV = 4
`ifdef T09_PWM_DAC_DEADBAND_EN
   ,
   parameter int DB  = 2
`endif
) (
   input  logic         clk,
   input  logic         nRst,
   input  logic         en,
   input  logic [N-1:0] sample_in,
   input  logic         sample_valid,
   output logic         sample_ready,
   output logic         at_max,
   output logic         pwm_out,
`ifdef T09_PWM_DAC_DEADBAND_EN
   output logic         pwm_out_n,
`endif
   output logic         underrun,
   output logic [N-1:0] duty
);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   logic [PW-1:0] prescaler;
   logic [N-1:0]  pwm_count;
   logic [N-1:0]  pending;
   logic          pending_full;
   logic          tick;
   logic          boundary;
   logic          wr;
   logic          cmp;

   assign tick         = en && (prescaler == PRE_LAST);
   assign boundary     = tick && (pwm_count == '1);
   assign sample_ready = ~pending_full;
   assign wr           = sample_valid && !pending_full;
   assign cmp          = en && (pwm_count < duty);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         prescaler    <= '0;
         pwm_count    <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
         duty         <= '0;
         at_max       <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         if (en) prescaler <= tick ? '0 : prescaler + 1'b1;
         if (tick) pwm_count <= pwm_count + 1'b1;
         at_max <= boundary;
         // A write landing on an empty-buffer boundary still counts as an underrun;
         // the new sample waits in pending for the next boundary.
         if (boundary) begin
            if (pending_full) begin
               duty         <= pending;
               pending_full <= 1'b0;
            end else begin
               underrun <= 1'b1;
            end
         end
         if (wr) begin
            pending      <= sample_in;
            pending_full <= 1'b1;
         end
      end
   end

`ifdef T09_PWM_DAC_DEADBAND_EN
   localparam int RW = $clog2(DB + 1) + 1;

   logic          cmp_last;
   logic [RW-1:0] run_len;
   logic [RW-1:0] run_now;

   function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
      return (v >= RW'(DB)) ? RW'(DB) : v + 1'b1;
   endfunction

   // run_now counts consecutive cycles (including this one) the compare has held its value.
   assign run_now = (cmp == cmp_last) ? sat_inc(run_len) : RW'(1);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         cmp_last  <= 1'b0;
         run_len   <= '0;
         pwm_out   <= 1'b0;
         pwm_out_n <= 1'b0;
      end else begin
         cmp_last  <= cmp;
         run_len   <= run_now;
         pwm_out   <= cmp && (run_now >= RW'(DB));
         pwm_out_n <= !cmp && (run_now >= RW'(DB));
      end
   end
`else
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) pwm_out <= 1'b0;
      else       pwm_out <= cmp;
   end
`endif

endmodule

// File: doc/t09_pwm_dac.md
Name: t09_pwm_dac

Overview:
- PWM output stage for the team_09 audio/DAC path.
- Runs a free-running N-bit period counter and emits `at_max` once per PWM period; the upstream DAC counter uses this as its advance strobe.
- Accepts new N-bit samples through a one-deep valid/ready buffer and drives a single-bit PWM pin whose duty equals the latched sample.
- Duty updates only at period boundaries, so the output is glitch-free.

Parameters:
- N, 8, sample and PWM counter width; period = 2^N ticks.
- DIV, 4, clock prescale; one tick every DIV clk cycles; DIV >= 1.

Ports:
- clk  input  1  system clock
- nRst  input  1  asynchronous, active-low reset
- en  input  1  run enable
- sample_in  input  N  next duty value
- sample_valid  input  1  sample_in is valid this cycle
- sample_ready  output  1  pending buffer empty, can accept a sample
- at_max  output  1  one-clk pulse at end of each PWM period
- pwm_out  output  1  registered PWM output
- underrun  output  1  sticky: a boundary passed with no pending sample
- duty  output  N  currently applied duty (debug)

Behaviour:
- Reset (asynchronous, nRst low):
  - prescaler, pwmCount, duty = 0; pending_full = 0.
  - at_max = 0, pwm_out = 0, underrun = 0; sample_ready = 1.
- Prescaler:
  - Counts 0..DIV-1 while en = 1; tick is asserted when prescaler == DIV-1, then the prescaler wraps to 0.
  - DIV = 1 means tick every cycle.
- Period counter:
  - On tick, pwmCount increments mod 2^N (wraps 2^N-1 -> 0).
- Boundary:
  - Boundary = tick && pwmCount == 2^N-1.
  - at_max is registered and high for exactly the one clk following the boundary cycle.
- Sample buffer:
  - sample_ready = ~pending_full.
  - Write when sample_valid && sample_ready: pending <= sample_in, pending_full <= 1.
  - sample_valid while not ready is ignored; upstream must hold.
- Duty load at boundary:
  - If pending_full: duty <= pending, pending_full <= 0.
  - Else: duty holds and underrun <= 1.
- Write coinciding with boundary while pending_full = 0:
  - The sample goes to pending (not directly to duty); pending_full = 1 after the edge.
  - underrun is still set for that boundary.
- Write coinciding with boundary while pending_full = 1:
  - Not possible, because sample_ready = 0 that cycle.
  - The new sample can be written from the following cycle.
- PWM output:
  - pwm_out(t+1) = en(t) && (pwmCount(t) < duty(t)).
  - duty = 0 gives constant 0; duty = 2^N-1 gives high for 2^N-1 of 2^N ticks (never 100%).
- en low:
  - prescaler and pwmCount are held (frozen, not cleared); no ticks, at_max = 0.
  - pwm_out = 0 from the next cycle.
  - Buffer writes still accepted.
  - Re-asserting en resumes from the frozen count.
- underrun is cleared only by reset.
- Reset mid-period: all state returns to reset values immediately; a pending sample is discarded.

Optional Feature:
- Macro: T09_PWM_DAC_DEADBAND_EN.
- When defined:
  - Adds parameter DB (default 2) and output pwm_out_n.
  - pwm_out is asserted only after (pwmCount < duty) has been stable-high for DB clk cycles.
  - pwm_out_n is the complementary leg, asserted only after the compare has been stable-low for DB clk cycles.
  - pwm_out and pwm_out_n are never both 1; both are 0 during the deadband.
  - Reset value of pwm_out_n = 0.
- When undefined:
  - No pwm_out_n port, no DB parameter.
  - pwm_out follows the compare with the single-register latency above.

Test Plan:
1. Reset, N=8, DIV=1, en=1, no samples -> at_max pulses every 256 clks, first pulse 256 clks after reset release; pwm_out = 0; underrun = 1 after first boundary; sample_ready = 1.
2. Write sample 0x40 mid-period -> sample_ready drops next cycle; duty stays 0 until boundary; then duty = 0x40, sample_ready = 1, pwm_out high exactly 64 of each 256 clks.
3. DIV=4, sample 0x80 -> at_max every 1024 clks; pwm_out high for 512 consecutive clks per period.
4. sample_valid held high with 0x10 then 0x20 back-to-back -> only 0x10 accepted until boundary; 0x20 accepted the cycle after boundary and applied at the following boundary.
5. Write landing in the boundary cycle with empty buffer -> underrun = 1; sample applied one period later.
6. en deasserted for 50 clks mid-period at pwmCount = 0x30, then reasserted -> pwm_out = 0 during the gap; pwmCount resumes at 0x30; period stretched by exactly 50 clks. Then pulse nRst low mid-period -> all outputs return to reset values asynchronously.
